// File: rtl/sdfm_data_filter_if.sv
// Signal bundle between the SDFM input-mode/register stage and one data-filter
// channel: the recovered bitstream, the DFPARMx fields, and the filtered result.
interface sdfm_data_filter_if #(
  parameter int OW = 32
);
  logic          sd_bit;
  logic          sd_strobe;
  logic          filt_en;
  logic [7:0]    filt_dec;
  logic [1:0]    filt_st;
  logic [4:0]    filt_sh;
  logic [OW-1:0] filt_data;
  logic          filt_data_update;

  modport master (
    output sd_bit, sd_strobe, filt_en, filt_dec, filt_st, filt_sh,
    input  filt_data, filt_data_update
  );

  modport slave (
    input  sd_bit, sd_strobe, filt_en, filt_dec, filt_st, filt_sh,
    output filt_data, filt_data_update
  );
endinterface

// File: rtl/sdfm_data_filter.sv
// One SDFM data-filter channel: sinc1..sinc4 CIC decimator with settling control,
// arithmetic output shift and saturation to a signed OW-bit result.
module sdfm_data_filter #(
  parameter int IW = 36,
  parameter int OW = 32
) (
  input  logic                SYSCLK,
  input  logic                SYSRSTn,
  sdfm_data_filter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             settle_q, settle_d;
  logic [7:0]             dec_cnt_q;
  logic [7:0]             dec_q;
  logic [1:0]             st_q;
  logic [3:0][IW-1:0]     integ_q;
  logic [3:0][IW-1:0]     comb_dly_q;

  logic                   param_chg;
  logic                   clear;
  logic                   accept;
  logic                   dec_event;
  logic                   do_update;
  logic [IW-1:0]          in_val;
  logic [IW-1:0]          sum0, sum1, sum2, sum3;
  logic [IW-1:0]          kth;
  logic [IW-1:0]          dif0, dif1, dif2, dif3;
  logic [IW-1:0]          comb_res;
  logic signed [IW-1:0]   shifted;
  logic [OW-1:0]          data_sat;

  // NOTE: combinational logic uses blocking '=' so later statements see the
  // values just computed; every output is given a default first so no latch
  // is inferred on paths that do not assign it.
  always_comb begin
    param_chg = (bus.filt_dec != dec_q) || (bus.filt_st != st_q);
    clear     = !bus.filt_en || (state_q == IDLE) || param_chg;
    accept    = !clear && bus.sd_strobe;
    dec_event = accept && (dec_cnt_q == bus.filt_dec);

    in_val = bus.sd_bit ? IW'(1) : {IW{1'b1}};

    // Integrators chain on this strobe's sums; wrap-around cancels in the combs.
    sum0 = integ_q[0] + in_val;
    sum1 = integ_q[1] + sum0;
    sum2 = integ_q[2] + sum1;
    sum3 = integ_q[3] + sum2;

    case (bus.filt_st)
      2'd0:    kth = sum0;
      2'd1:    kth = sum1;
      2'd2:    kth = sum2;
      default: kth = sum3;
    endcase

    dif0 = kth  - comb_dly_q[0];
    dif1 = dif0 - comb_dly_q[1];
    dif2 = dif1 - comb_dly_q[2];
    dif3 = dif2 - comb_dly_q[3];

    case (bus.filt_st)
      2'd0:    comb_res = dif0;
      2'd1:    comb_res = dif1;
      2'd2:    comb_res = dif2;
      default: comb_res = dif3;
    endcase

    shifted = $signed(comb_res) >>> bus.filt_sh;
    if ((&shifted[IW-1:OW-1]) || !(|shifted[IW-1:OW-1])) begin
      data_sat = shifted[OW-1:0];
    end else if (shifted[IW-1]) begin
      data_sat = {1'b1, {(OW-1){1'b0}}};
    end else begin
      data_sat = {1'b0, {(OW-1){1'b1}}};
    end
  end

  // A structure change needs K-1 discarded events before the comb delays hold
  // a full window; settle_q counts those events.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    do_update = 1'b0;
    if (!bus.filt_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          settle_d = 2'd0;
        end
        SETTLE: begin
          if (param_chg) begin
            settle_d = 2'd0;
          end else if (settle_q == bus.filt_st) begin
            state_d   = RUN;
            do_update = dec_event;
          end else if (dec_event) begin
            settle_d = settle_q + 2'd1;
          end
        end
        RUN: begin
          if (param_chg) begin
            state_d  = SETTLE;
            settle_d = 2'd0;
          end else begin
            do_update = dec_event;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      state_q  <= IDLE;
      settle_q <= 2'd0;
      dec_q    <= 8'd0;
      st_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      dec_q    <= bus.filt_dec;
      st_q     <= bus.filt_st;
    end
  end

  // NOTE: the integrator and comb-delay arrays are real state that must start
  // from zero, so they are reset like any other register.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      integ_q    <= '0;
      comb_dly_q <= '0;
      dec_cnt_q  <= 8'd0;
    end else if (clear) begin
      integ_q    <= '0;
      comb_dly_q <= '0;
      dec_cnt_q  <= 8'd0;
    end else if (accept) begin
      integ_q   <= {sum3, sum2, sum1, sum0};
      dec_cnt_q <= dec_event ? 8'd0 : dec_cnt_q + 8'd1;
      if (dec_event) begin
        comb_dly_q <= {dif2, dif1, dif0, kth};
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      bus.filt_data        <= '0;
      bus.filt_data_update <= 1'b0;
    end else begin
      bus.filt_data_update <= do_update;
      if (do_update) begin
        bus.filt_data <= data_sat;
      end
    end
  end

endmodule
